rr_client_bank: RTL and testbench
=================================

# rr_client_bank

Four-client request generator: the requesting side of the 4-bit round-robin request/grant interface. Each client queues jobs, raises its request line while work is pending, consumes each grant for a fixed hold window, and then drops its request for one cycle so the arbiter can rotate. The block sits between the job sources and the arbiter: `req` drives the arbiter request input and the arbiter grant output drives `gnt`.

## Interface
- `HOLD`, default 2: number of cycles a grant is used per job (1..15).
- `CNT_W`, default 3: pending-counter width; the maximum pending count per client is 2^CNT_W-1.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `job_valid` in 4: per-client job offer.
- `job_ready` out 4: per-client job acceptance; `job_ready[i] = (pend[i] != max)`, combinational from registered state.
- `req` out 4: registered request lines to the arbiter.
- `gnt` in 4: grant lines from the arbiter; expected one-hot or zero.
- `busy` out 4: registered; high while client i is in XFER.
- `done` out 4: registered one-cycle pulse when client i completes a job.
- `err` out 1: registered, sticky protocol-error flag.

## Operation
- Per-client state: `pend[i]` (CNT_W bits), a 2-bit FSM, and a hold counter (4 bits).
- Job accept: a job is accepted when `job_valid[i] && job_ready[i]`, which increments `pend[i]`. When an accept and a completion happen in the same cycle, `pend[i]` is unchanged. Counters never wrap.
- IDLE: `req[i]=0`. Moves to REQ when `pend[i]>0`, or in the same cycle that an accept makes it nonzero, so `req` rises the cycle after the first accept.
- REQ: `req[i]=1`. When `gnt[i]=1` is sampled, moves to XFER and loads hold counter = HOLD-1.
- XFER: `req[i]=1` and `busy[i]=1`. The hold counter decrements each cycle and `gnt[i]` is ignored. When the counter reaches 0: `pend[i]` decrements, `done[i]` pulses on the next cycle, and the FSM moves to GAP.
- GAP: exactly one cycle with `req[i]=0`. Then moves to REQ if `pend[i]>0`, else to IDLE.
- Clients are fully independent; any number may be in REQ at once.
- `err` is set, and held until `rst`, on either of:
  - more than one bit of `gnt` set in a cycle;
  - `gnt[i]=1` while client i is in IDLE or GAP.
- A grant in XFER is legal: the arbiter may hold the grant.
- When `err` is set, a multi-hot grant is still acted on per client; this is not corrected.

## Timing
- Reset values: `req=0`, `busy=0`, `done=0`, `err=0`, all `pend=0`, all FSMs IDLE, so `job_ready=4'b1111`.
- Reset mid-operation immediately clears everything. Pending jobs are discarded and no `done` pulse is issued.
- Latency:
  - accept at edge T → `req` high after T;
  - `gnt` sampled at edge G → `busy` high from G through G+HOLD-1;
  - `done` and `req` low at G+HOLD;
  - `req` high again at G+HOLD+1 if more jobs are pending.
- Per-client throughput is one job per HOLD+2 cycles under continuous grant.
- Full boundary: at `pend=max`, `job_ready=0`. In the completion cycle `job_ready` stays 0; it rises the following cycle.

## Test plan
- Reset, then one job on client 3 (`job_valid=4'b1000`), with the bench granting `gnt=4'b1000` the cycle after `req` rises → `req=4'b1000`; `busy[3]` high for 2 cycles; one `done[3]` pulse; `req` returns to 0; `pend[3]=0`.
- Jobs on clients 1 and 3 together, with the bench acting as a round-robin arbiter → grants alternate; each client shows `req` low for exactly 1 GAP cycle between jobs; `done` counts equal the accepted jobs.
- Push 8 jobs into client 0 with `gnt` held 0 → 7 accepted, `job_ready[0]=0` after the 7th. Then grant continuously → 7 `done[0]` pulses spaced 4 cycles apart (HOLD=2).
- Accept and completion in the same cycle on client 2 → `pend[2]` unchanged and `req[2]` resumes after GAP.
- Inject `gnt=4'b0110`, and separately `gnt=4'b0001` with client 0 idle → `err` rises the next cycle and stays high until `rst`.
- Assert `rst` while client 1 is in XFER → `req`, `busy`, `done` and `err` are 0 at once; `job_ready=4'b1111`; no `done` after deassertion.

Source files
------------

// File: rtl/rr_client_bank_if.sv
// rtl/rr_client_bank_if.sv - job/request/grant bundle between job sources, client bank and arbiter
interface rr_client_bank_if;
    logic [3:0] job_valid;
    logic [3:0] job_ready;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] busy;
    logic [3:0] done;
    logic       err;

    modport master (
        output job_valid,
        output gnt,
        input  job_ready,
        input  req,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  job_valid,
        input  gnt,
        output job_ready,
        output req,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/rr_client_bank.sv
// rtl/rr_client_bank.sv - four independent job-queuing clients driving a round-robin arbiter
module rr_client_bank #(
    parameter int HOLD  = 2,
    parameter int CNT_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    rr_client_bank_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX  = '1;
    localparam logic [CNT_W-1:0] PEND_ZERO = '0;
    localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);
    localparam logic [3:0]       HOLD_INIT = 4'(HOLD - 1);

    state_t           state     [4];
    state_t           state_nxt [4];
    logic [3:0]       hold      [4];
    logic [3:0]       hold_nxt  [4];
    logic [CNT_W-1:0] pend      [4];
    logic [CNT_W-1:0] pend_nxt  [4];

    logic [3:0] ready;
    logic [3:0] accept;
    logic [3:0] complete;
    logic [3:0] req_d;
    logic [3:0] busy_d;
    logic [3:0] done_d;
    logic       err_d;
    logic       multi_hot;
    logic       stray_gnt;

    logic [3:0] req_q;
    logic [3:0] busy_q;
    logic [3:0] done_q;
    logic       err_q;

    // Acceptance is decided purely from the registered pending count so a full client never sees a combinational path from gnt.
    always_comb begin
        ready = '0;
        for (int i = 0; i < 4; i++) begin
            ready[i] = (pend[i] != PEND_MAX);
        end
        accept = bus.job_valid & ready;
    end

    // Next-state logic: per-client FSM, hold countdown and pending-count bookkeeping.
    always_comb begin
        complete = '0;
        for (int i = 0; i < 4; i++) begin
            state_nxt[i] = state[i];
            hold_nxt[i]  = hold[i];
            pend_nxt[i]  = pend[i];
            case (state[i])
                IDLE: begin
                    if ((pend[i] != PEND_ZERO) || accept[i]) begin
                        state_nxt[i] = REQ;
                    end
                end
                REQ: begin
                    if (bus.gnt[i]) begin
                        state_nxt[i] = XFER;
                        hold_nxt[i]  = HOLD_INIT;
                    end
                end
                XFER: begin
                    if (hold[i] == 4'd0) begin
                        complete[i]  = 1'b1;
                        state_nxt[i] = GAP;
                    end else begin
                        hold_nxt[i] = hold[i] - 4'd1;
                    end
                end
                GAP: begin
                    // Request drops for exactly this cycle so the arbiter can rotate.
                    if ((pend[i] != PEND_ZERO) || accept[i]) begin
                        state_nxt[i] = REQ;
                    end else begin
                        state_nxt[i] = IDLE;
                    end
                end
                default: state_nxt[i] = IDLE;
            endcase
            // Simultaneous accept and completion cancel out; the guards keep the counter from wrapping.
            if (accept[i] && !complete[i]) begin
                pend_nxt[i] = pend[i] + PEND_ONE;
            end else if (complete[i] && !accept[i] && (pend[i] != PEND_ZERO)) begin
                pend_nxt[i] = pend[i] - PEND_ONE;
            end
        end
    end

    // Output logic: values the output flops take at the next edge, plus protocol-error detection on the live grant.
    always_comb begin
        req_d     = '0;
        busy_d    = '0;
        stray_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_d[i]  = (state_nxt[i] == REQ) || (state_nxt[i] == XFER);
            busy_d[i] = (state_nxt[i] == XFER);
            if (bus.gnt[i] && ((state[i] == IDLE) || (state[i] == GAP))) begin
                stray_gnt = 1'b1;
            end
        end
        done_d    = complete;
        multi_hot = |(bus.gnt & (bus.gnt - 4'd1));
        err_d     = err_q | multi_hot | stray_gnt;
    end

    // State and output registers; reset discards all pending work immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= IDLE;
                hold[i]  <= 4'd0;
                pend[i]  <= PEND_ZERO;
            end
            req_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= state_nxt[i];
                hold[i]  <= hold_nxt[i];
                pend[i]  <= pend_nxt[i];
            end
            req_q  <= req_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign bus.job_ready = ready;
    assign bus.req       = req_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_rr_client_bank.sv
// tb/tb_rr_client_bank.sv - directed self-checking bench for rr_client_bank
module tb_rr_client_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rr_client_bank_if bus ();

    rr_client_bank #(
        .HOLD  (2),
        .CNT_W (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int         last;
        int         ngrant;
        int         dcnt [4];
        int         nd;
        int         last_t;
        logic [3:0] g;
        logic [3:0] prev_g;
        logic [3:0] prev_req;
        logic [3:0] gap_pending;
        logic       prev_ready;

        bus.job_valid = 4'b0000;
        bus.gnt       = 4'b0000;
        rst           = 1'b1;
        tick();
        tick();

        // reset state
        check("rst_req",   8'(bus.req),       8'h00);
        check("rst_busy",  8'(bus.busy),      8'h00);
        check("rst_done",  8'(bus.done),      8'h00);
        check("rst_err",   8'(bus.err),       8'h00);
        check("rst_ready", 8'(bus.job_ready), 8'h0f);
        rst = 1'b0;
        tick();

        // single job on client 3
        bus.job_valid = 4'b1000;
        tick();
        bus.job_valid = 4'b0000;
        check("t1_req",   8'(bus.req),       8'h08);
        check("t1_ready", 8'(bus.job_ready), 8'h0f);
        bus.gnt = 4'b1000;
        tick();
        bus.gnt = 4'b0000;
        check("t1_busy0", 8'(bus.busy), 8'h08);
        check("t1_req0",  8'(bus.req),  8'h08);
        tick();
        check("t1_busy1", 8'(bus.busy), 8'h08);
        check("t1_done1", 8'(bus.done), 8'h00);
        tick();
        check("t1_busy2", 8'(bus.busy), 8'h00);
        check("t1_done2", 8'(bus.done), 8'h08);
        check("t1_req2",  8'(bus.req),  8'h00);
        tick();
        check("t1_done3", 8'(bus.done),      8'h00);
        check("t1_req3",  8'(bus.req),       8'h00);
        check("t1_ready3", 8'(bus.job_ready), 8'h0f);
        check("t1_err",   8'(bus.err),       8'h00);

        // two jobs each on clients 1 and 3, bench acts as round-robin arbiter
        bus.job_valid = 4'b1010;
        tick();
        tick();
        bus.job_valid = 4'b0000;
        last        = 3;
        ngrant      = 0;
        prev_g      = 4'b0000;
        prev_req    = bus.req;
        gap_pending = 4'b0000;
        for (int i = 0; i < 4; i++) dcnt[i] = 0;
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < 4; i++) begin
                dcnt[i] += int'(bus.done[i]);
                if (gap_pending[i]) begin
                    check("t2_gap_one_cycle", 8'(bus.req[i]), 8'h01);
                    gap_pending[i] = 1'b0;
                end else if (prev_req[i] && !bus.req[i] && dcnt[i] < 2) begin
                    gap_pending[i] = 1'b1;
                end
            end
            g = 4'b0000;
            if (bus.busy == 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    int idx;
                    idx = (last + k) % 4;
                    if (bus.req[idx] && g == 4'b0000) begin
                        g[idx] = 1'b1;
                        last   = idx;
                    end
                end
            end
            if (g != 4'b0000) begin
                if (prev_g != 4'b0000) begin
                    check("t2_alternate", 8'(g != prev_g), 8'h01);
                end
                prev_g = g;
                ngrant++;
            end
            bus.gnt  = g;
            prev_req = bus.req;
            tick();
        end
        bus.gnt = 4'b0000;
        check("t2_done1", 8'(dcnt[1]), 8'd2);
        check("t2_done3", 8'(dcnt[3]), 8'd2);
        check("t2_ngrant", 8'(ngrant), 8'd4);
        check("t2_req",   8'(bus.req), 8'h00);
        check("t2_err",   8'(bus.err), 8'h00);

        // fill client 0 to its limit, then drain under continuous grant
        bus.job_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            check("t3_ready_fill", 8'(bus.job_ready[0]), (k < 7) ? 8'h01 : 8'h00);
            tick();
        end
        bus.job_valid = 4'b0000;
        check("t3_ready_full", 8'(bus.job_ready[0]), 8'h00);
        check("t3_req",        8'(bus.req),          8'h01);
        nd         = 0;
        last_t     = -1;
        prev_ready = bus.job_ready[0];
        for (int c = 0; c < 40; c++) begin
            if (bus.done[0]) begin
                nd++;
                if (last_t >= 0) begin
                    check("t3_spacing", 8'(c - last_t), 8'd4);
                end
                if (nd == 1) begin
                    check("t3_ready_in_completion", 8'(prev_ready),         8'h00);
                    check("t3_ready_after",         8'(bus.job_ready[0]),  8'h01);
                end
                last_t = c;
            end
            prev_ready = bus.job_ready[0];
            bus.gnt    = {3'b000, bus.req[0]};
            tick();
        end
        bus.gnt = 4'b0000;
        check("t3_ndone", 8'(nd),      8'd7);
        check("t3_req",   8'(bus.req), 8'h00);
        check("t3_err",   8'(bus.err), 8'h00);

        // accept and completion in the same cycle on client 2
        bus.job_valid = 4'b0100;
        tick();
        bus.job_valid = 4'b0000;
        check("t4_req", 8'(bus.req), 8'h04);
        bus.gnt = 4'b0100;
        tick();
        bus.gnt = 4'b0000;
        check("t4_busy0", 8'(bus.busy), 8'h04);
        tick();
        check("t4_busy1", 8'(bus.busy), 8'h04);
        bus.job_valid = 4'b0100;
        tick();
        bus.job_valid = 4'b0000;
        check("t4_done",   8'(bus.done),   8'h04);
        check("t4_req_gap", 8'(bus.req[2]), 8'h00);
        tick();
        check("t4_req_resume", 8'(bus.req[2]), 8'h01);
        bus.gnt = 4'b0100;
        tick();
        bus.gnt = 4'b0000;
        tick();
        tick();
        check("t4_done2", 8'(bus.done[2]), 8'h01);
        tick();
        check("t4_req_idle", 8'(bus.req[2]), 8'h00);
        tick();
        check("t4_req_idle2", 8'(bus.req), 8'h00);
        check("t4_err",       8'(bus.err), 8'h00);

        // protocol errors: multi-hot grant, then grant to an idle client
        bus.gnt = 4'b0110;
        tick();
        bus.gnt = 4'b0000;
        check("t5_multi_err", 8'(bus.err), 8'h01);
        tick();
        tick();
        tick();
        check("t5_multi_sticky", 8'(bus.err), 8'h01);
        rst = 1'b1;
        tick();
        check("t5_rst_err", 8'(bus.err), 8'h00);
        rst = 1'b0;
        tick();
        check("t5_pre_idle_err", 8'(bus.err), 8'h00);
        bus.gnt = 4'b0001;
        tick();
        bus.gnt = 4'b0000;
        check("t5_idle_err", 8'(bus.err), 8'h01);
        tick();
        tick();
        check("t5_idle_sticky", 8'(bus.err), 8'h01);

        // reset while client 1 is transferring
        bus.job_valid = 4'b0010;
        tick();
        bus.job_valid = 4'b0000;
        bus.gnt = 4'b0010;
        tick();
        bus.gnt = 4'b0000;
        check("t6_busy", 8'(bus.busy), 8'h02);
        rst = 1'b1;
        #1;
        check("t6_req",   8'(bus.req),       8'h00);
        check("t6_busy0", 8'(bus.busy),      8'h00);
        check("t6_done",  8'(bus.done),      8'h00);
        check("t6_err",   8'(bus.err),       8'h00);
        check("t6_ready", 8'(bus.job_ready), 8'h0f);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("t6_no_done", 8'({bus.done, bus.req}), 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
